// File: rtl/latch_ctrl_pkg.sv
// Purpose : shared types and defaults for the latch bank write sequencer.
// Latency : n/a (package only).
// Backpressure: n/a.
// Contents: state_t sequencer states, default bank width / requester count,
//           max3() helper used to size the shared phase counter.
package latch_ctrl_pkg;

  localparam int DEFAULT_WIDTH = 8;
  localparam int DEFAULT_N     = 4;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    WRITE,
    HOLD,
    CLEAR
  } state_t;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return m;
  endfunction

endpackage

// File: rtl/latch_write_arbiter_rr_arbiter.sv
// Purpose : combinational round-robin pick, first set req bit at or after rr_ptr.
// Latency : 0 cycles (pure combinational).
// Backpressure: none; caller samples the result only when it can start a write.
// Ports: req (N request levels), rr_ptr (search start index),
//        grant_onehot / grant_idx (winner), grant_any (some bit was set).
module rr_arbiter #(
  parameter int N = 4
) (
  input  logic [N-1:0]         req,
  input  logic [$clog2(N)-1:0] rr_ptr,
  output logic [N-1:0]         grant_onehot,
  output logic [$clog2(N)-1:0] grant_idx,
  output logic                 grant_any
);

  localparam int IW = $clog2(N);

  int cand;

  // Walk offsets 0..N-1 from rr_ptr; the first hit wins, so the requester
  // just served (rr_ptr-1) is always considered last.
  always_comb begin
    grant_any = 1'b0;
    grant_idx = '0;
    cand      = 0;
    for (int j = 0; j < N; j++) begin
      cand = (int'(rr_ptr) + j) % N;
      if (!grant_any && req[cand]) begin
        grant_any = 1'b1;
        grant_idx = IW'(cand);
      end
    end
  end

  always_comb begin
    grant_onehot = '0;
    for (int i = 0; i < N; i++) begin
      grant_onehot[i] = grant_any && (grant_idx == IW'(i));
    end
  end

endmodule

// File: rtl/latch_write_arbiter.sv
// Purpose : shares one level-sensitive latch bank among N writers, framing each
//           enable pulse with setup/hold phases so data never moves while open.
// Latency : grant 1 cycle after req sampled in IDLE; done after SETUP+WRITE+HOLD.
// Backpressure: req/clear_req are held levels; one transaction at a time, others wait.
// Ports: clk, reset (sync, active-high); req/din from clients; clear_req;
//        grant/done/clear_done back to clients; latch_d/latch_enable/latch_reset to bank.
module latch_write_arbiter
  import latch_ctrl_pkg::*;
#(
  parameter int WIDTH     = DEFAULT_WIDTH,
  parameter int N         = DEFAULT_N,
  parameter int SETUP_CYC = 1,
  parameter int WRITE_CYC = 1,
  parameter int HOLD_CYC  = 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [N-1:0]       req,
  input  logic [N*WIDTH-1:0] din,
  input  logic               clear_req,
  output logic [N-1:0]       grant,
  output logic [N-1:0]       done,
  output logic               clear_done,
  output logic [WIDTH-1:0]   latch_d,
  output logic               latch_enable,
  output logic               latch_reset
);

  localparam int IW   = $clog2(N);
  localparam int MAXC = max3(SETUP_CYC, WRITE_CYC, HOLD_CYC);
  localparam int CW   = $clog2(MAXC + 1);

  state_t          state;
  logic [CW-1:0]   cnt;
  logic [IW-1:0]   rr_ptr;
  logic [IW-1:0]   owner_idx;

  logic [N-1:0]     arb_onehot;
  logic [IW-1:0]    arb_idx;
  logic             arb_any;
  logic [WIDTH-1:0] sel_din;

  rr_arbiter #(.N(N)) u_arb (
    .req          (req),
    .rr_ptr       (rr_ptr),
    .grant_onehot (arb_onehot),
    .grant_idx    (arb_idx),
    .grant_any    (arb_any)
  );

  always_comb begin
    sel_din = '0;
    for (int i = 0; i < N; i++) begin
      if (arb_idx == IW'(i)) sel_din = din[i*WIDTH +: WIDTH];
    end
  end

  // The bank must clear while the block itself is held in reset, so reset
  // bypasses the registers here.
  assign latch_reset = reset | (state == CLEAR);

  // Pulses (done, clear_done) are registered, so they are armed on the edge
  // that enters the final cycle of their phase: directly on phase entry when
  // the phase is one cycle long, otherwise when the counter reaches 1.
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      cnt          <= '0;
      rr_ptr       <= '0;
      owner_idx    <= '0;
      grant        <= '0;
      done         <= '0;
      clear_done   <= 1'b0;
      latch_d      <= '0;
      latch_enable <= 1'b0;
    end else begin
      done       <= '0;
      clear_done <= 1'b0;
      case (state)
        IDLE: begin
          if (clear_req) begin
            state      <= CLEAR;
            cnt        <= CW'(WRITE_CYC - 1);
            clear_done <= (WRITE_CYC == 1);
          end else if (arb_any) begin
            state     <= SETUP;
            cnt       <= CW'(SETUP_CYC - 1);
            grant     <= arb_onehot;
            owner_idx <= arb_idx;
            latch_d   <= sel_din;
          end
        end
        SETUP: begin
          if (cnt == '0) begin
            state        <= WRITE;
            cnt          <= CW'(WRITE_CYC - 1);
            latch_enable <= 1'b1;
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        WRITE: begin
          if (cnt == '0) begin
            state        <= HOLD;
            cnt          <= CW'(HOLD_CYC - 1);
            latch_enable <= 1'b0;
            done         <= (HOLD_CYC == 1) ? grant : '0;
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        HOLD: begin
          if (cnt == '0) begin
            state  <= IDLE;
            grant  <= '0;
            rr_ptr <= (owner_idx == IW'(N - 1)) ? '0 : owner_idx + IW'(1);
          end else begin
            cnt <= cnt - CW'(1);
            if (cnt == CW'(1)) done <= grant;
          end
        end
        CLEAR: begin
          if (cnt == '0) begin
            state <= IDLE;
          end else begin
            cnt <= cnt - CW'(1);
            if (cnt == CW'(1)) clear_done <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
